// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC owner with redirect, stall, imem-wait and debug-halt control.
module pc_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              id_jump,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              hazard_stall,
  input  logic              imem_ready,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [15:0]       stall_cycles
);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_target_q, pend_target_d, run_pc;
  logic              pend_valid_q, pend_valid_d;
  logic [15:0]       stall_cycles_q, stall_cycles_d;
  logic              halted, jump_eff, take_halt, hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_RUN;
      pc_q           <= RESET_PC;
      pend_valid_q   <= 1'b0;
      pend_target_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_valid_q   <= pend_valid_d;
      pend_target_q  <= pend_target_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // A jump held in ID by a load-use stall is not a request yet.
  always_comb begin
    halted    = state_q == S_HALT;
    jump_eff  = id_jump & ~hazard_stall;
    take_halt = halt_req & imem_ready & ~ex_redirect & ~jump_eff & ~pend_valid_q;
    state_d   = halted ? (resume ? S_RUN : S_HALT) : ~imem_ready ? S_WAIT : take_halt ? S_HALT : S_RUN;
  end

  always_comb begin
    run_pc         = ex_redirect ? ex_target : pend_valid_q ? pend_target_q :
                     hazard_stall ? pc_q : jump_eff ? id_target : pc_q + ADDR_W'(1);
    pc_d           = (halted | ~imem_ready) ? pc_q : run_pc;
    hold           = ~halted & (~imem_ready | (~ex_redirect & ~pend_valid_q & hazard_stall));
    stall_cycles_d = (hold && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 16'd1 : stall_cycles_q;
    pend_valid_d   = halted ? pend_valid_q : ~imem_ready & (ex_redirect | jump_eff | pend_valid_q);
    pend_target_d  = (halted | imem_ready) ? pend_target_q : ex_redirect ? ex_target :
                     (jump_eff & ~pend_valid_q) ? id_target : pend_target_q;
    pc             = pc_q;
    pc_valid       = ~halted;
    stall_cycles   = stall_cycles_q;
    stall_ifid     = hazard_stall & ~ex_redirect & ~halted;
    flush_idex     = ex_redirect | stall_ifid;
    flush_ifid     = ex_redirect | jump_eff | (~stall_ifid & (~imem_ready | pend_valid_q | halted));
  end
endmodule
